// File: rtl/shift_rows_pipe_if.sv
// Handshake bundle for shift_rows_pipe: input side, output side, mode bit.
// master drives blocks in and accepts results; slave is the stage itself.
interface shift_rows_pipe_if #(
    parameter int NB = 4
) ();
    localparam int W = 32 * NB;

    logic         in_valid;
    logic         in_ready;
    logic         in_inv;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_inv;

    modport master (
        output in_valid,
        output in_inv,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_inv
    );

    modport slave (
        input  in_valid,
        input  in_inv,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_inv
    );
endinterface

// File: rtl/shift_rows_pipe.sv
// AES ShiftRows/InvShiftRows stage (NB = 4/6/8) with 2-entry elastic output.
// Define SHIFT_ROWS_BLK_CNT_EN to add the blk_cnt output-transfer counter.
module shift_rows_pipe #(
    parameter int NB = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    shift_rows_pipe_if.slave    bus
`ifdef SHIFT_ROWS_BLK_CNT_EN
    ,
    output logic [15:0]         blk_cnt
`endif
);
    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    function automatic int row_off(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    logic [W-1:0] w_fwd;
    logic [W-1:0] w_inv;
    logic [W-1:0] w_res;

    // Pure wiring: every output byte picks a fixed source byte.
    for (genvar gc = 0; gc < NB; gc++) begin : g_col
        for (genvar gr = 0; gr < 4; gr++) begin : g_row
            localparam int SF = (gc + row_off(gr)) % NB;
            localparam int SI = (gc - row_off(gr) + NB) % NB;
            localparam int DO = W - 1 - 8 * (4 * gc + gr);
            localparam int FO = W - 1 - 8 * (4 * SF + gr);
            localparam int IO = W - 1 - 8 * (4 * SI + gr);
            assign w_fwd[DO -: 8] = bus.in_data[FO -: 8];
            assign w_inv[DO -: 8] = bus.in_data[IO -: 8];
        end
    end

    assign w_res = bus.in_inv ? w_inv : w_fwd;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_e0;
    logic [W-1:0] r_e1;
    logic         r_e0_inv;
    logic         r_e1_inv;
    logic         w_push;
    logic         w_pop;
    logic         w_ld_e0_res;
    logic         w_ld_e0_e1;
    logic         w_ld_e1;

    assign bus.in_ready  = (r_state != S_FULL);
    assign bus.out_valid = (r_state != S_EMPTY);
    assign bus.out_data  = r_e0;
    assign bus.out_inv   = r_e0_inv;

    assign w_push = bus.in_valid & bus.in_ready;
    assign w_pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        w_next      = r_state;
        w_ld_e0_res = 1'b0;
        w_ld_e0_e1  = 1'b0;
        w_ld_e1     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_push) begin
                    w_ld_e0_res = 1'b1;
                    w_next      = S_ONE;
                end
            end
            S_ONE: begin
                if (w_push && w_pop) begin
                    w_ld_e0_res = 1'b1;
                end else if (w_push) begin
                    w_ld_e1 = 1'b1;
                    w_next  = S_FULL;
                end else if (w_pop) begin
                    w_next = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_ld_e0_e1 = 1'b1;
                    w_next     = S_ONE;
                end
            end
            default: w_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e0     <= '0;
            r_e0_inv <= 1'b0;
            r_e1     <= '0;
            r_e1_inv <= 1'b0;
        end else begin
            if (w_ld_e0_res) begin
                r_e0     <= w_res;
                r_e0_inv <= bus.in_inv;
            end else if (w_ld_e0_e1) begin
                r_e0     <= r_e1;
                r_e0_inv <= r_e1_inv;
            end
            if (w_ld_e1) begin
                r_e1     <= w_res;
                r_e1_inv <= bus.in_inv;
            end
        end
    end

`ifdef SHIFT_ROWS_BLK_CNT_EN
    logic [15:0] r_blk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt <= 16'd0;
        end else if (w_pop) begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`endif
endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, handshaked ShiftRows/InvShiftRows stage for the AES/Rijndael datapath. It supports state widths of NB = 4, 6 or 8 columns.
- A per-transaction mode bit selects forward or inverse shifting.
- Results land in a 2-entry elastic output buffer, so `in_ready` is driven from state only.
- Sits between SubBytes and MixColumns in the iterative round core. It can also be chained stage-to-stage in an unrolled pipeline.

Parameters:
- NB, 4, number of 32-bit state columns; legal values 4, 6, 8 only. Any other value fails elaboration via a generate-time error.
- W, 32*NB, state width in bits (derived; not to be overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input block present
- in_ready  output  1  stage can accept a block this cycle
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with `in_data`
- in_data  input  W  state; byte k at bits [W-1-8k -: 8]; k = 4*col + row (column-major, byte 0 in the MSBs)
- out_valid  output  1  output block present
- out_ready  input  1  downstream accepts
- out_data  output  W  shifted state, same byte ordering
- out_inv  output  1  mode bit travelling with `out_data`

Behaviour:
- Reset is asynchronous on `rst_n` low and takes effect immediately. On reset:
  - count = 0, `out_valid` = 0, `in_ready` = 1;
  - both buffer entries and `out_data` = 0, `out_inv` = 0.
  - Blocks in flight are discarded. There is no partial output after reset deassertion.
- Row offsets C[r] for r = 0..3:
  - NB = 4 or 6: {0, 1, 2, 3};
  - NB = 8: {0, 1, 3, 4}.
- Forward: out[r][c] = in[r][(c + C[r]) mod NB]. Inverse: out[r][c] = in[r][(c - C[r] + NB) mod NB].
- The permutation is combinational on the input side. The registered result goes into the buffer.
- Input transfer occurs when `in_valid` and `in_ready`. Output transfer occurs when `out_valid` and `out_ready`.
- Buffer:
  - 2 entries, E0 = head, E1 = tail, with count in 0..2.
  - `out_data`/`out_inv` are driven directly from E0.
  - `out_valid` = (count != 0).
  - `in_ready` = (count != 2), a registered/state-derived signal with no combinational path from `out_ready`.
- Count transitions:
  - count 0, push: E0 <= result, count 1. Latency is 1 cycle from accept to `out_valid`.
  - count 1, push only: E1 <= result, count 2.
  - count 1, pop only: count 0. E0 holds stale data; `out_valid` = 0.
  - count 1, push and pop in the same cycle: E0 <= result, count stays 1. This gives full throughput of 1 block/cycle.
  - count 2, pop: E0 <= E1, count 1. No push is possible because `in_ready` = 0.
- Data on `out_data` must stay stable while `out_valid` = 1 and `out_ready` = 0.
- `in_data`/`in_inv` when `in_valid` = 0 are don't-care. Nothing is captured.
- Ordering is strict FIFO. Each block's mode bit stays paired with its data.

Optional Feature:
- Macro: SHIFT_ROWS_BLK_CNT_EN.
- With the macro defined:
  - adds output `blk_cnt` [15:0], reset to 0 by `rst_n`;
  - increments by 1 on every output transfer;
  - wraps from 0xFFFF to 0x0000.
- Without it: the port and counter do not exist; datapath behaviour is identical.

Test Plan:
- NB=4, `in_inv`=0, `in_data` bytes 00 01 02 .. 0f (k = k), `out_ready`=1 → after 1 cycle, `out_data` bytes = 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b, `out_inv`=0.
- NB=4, `in_inv`=1, same input → bytes = 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03. Forward then inverse through two chained instances returns the original block.
- NB=8, `in_inv`=0, bytes 00..1f → column 0 = 00 05 0e 13. Column 7 = 1c 01 0a 0f (offsets 0,1,3,4).
- Backpressure with `out_ready`=0:
  - push blocks A, B → `in_ready` drops to 0 in the cycle after B is accepted;
  - `out_data` holds A stable for 5 cycles;
  - raise `out_ready` → A then B emerge in order, and `in_ready` returns to 1 one cycle after the first pop.
- Streaming: 100 random blocks with random per-block `in_inv`, `out_ready` = 1 always → one output per cycle, matching a reference permutation model.
- Reset mid-operation: with count=2 and `out_valid`=1, pulse `rst_n` low asynchronously between edges → `out_valid`=0 and `in_ready`=1 immediately; no stale block appears after release. If SHIFT_ROWS_BLK_CNT_EN is defined, `blk_cnt`=0 after reset.
